// File: rtl/hram_cmd_parser.sv
// UART command parser for a HyperRAM controller. Each frame is a command byte plus
// a 32-bit operand, MSB first. Every frame is answered with a 4-byte reply, MSB first.
//
// state   | meaning
// RX      | collect 5 frame bytes; discard a partial frame after FRAME_TIMEOUT idle cycles
// EXEC    | decode the command and latch the reply word
// ISSUE   | wait for the controller to go idle, then pulse wr_req or rd_req
// TX_SEND | wait for tx_ready, then send the top reply byte
// TX_ACK  | wait for the transmitter to accept the byte
// TX_DONE | wait for the transmitter to go idle after the last byte
module hram_cmd_parser #(
  parameter logic [23:0] FRAME_TIMEOUT = 24'd1_000_000,
  parameter logic [31:0] CONST_VAL     = 32'd259
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rcv,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic [31:0] wr_d,
  output logic        wr_req,
  output logic        rd_req,
  input  logic        busy,
  input  logic        rd_rdy,
  input  logic [31:0] rd_d
);

  typedef enum logic [2:0] {RX, EXEC, ISSUE, TX_SEND, TX_ACK, TX_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [39:0] frame_q, frame_d;
  logic [31:0] reply_q, reply_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_d_q, wr_d_d;
  logic [31:0] ram_data_q, ram_data_d;
  logic [31:0] count_q, count_d;
  logic        drop_q, drop_d;
  logic        pend_q, pend_d;
  logic        is_wr_q, is_wr_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;

  // Requests are decoded from state so they can never coincide with busy=1.
  assign wr_req   = (state_q == ISSUE) && !busy && is_wr_q;
  assign rd_req   = (state_q == ISSUE) && !busy && !is_wr_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign addr     = addr_q;
  assign wr_d     = wr_d_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    frame_d    = frame_q;
    reply_d    = reply_q;
    addr_d     = addr_q;
    wr_d_d     = wr_d_q;
    ram_data_d = ram_data_q;
    count_d    = count_q;
    drop_d     = drop_q;
    pend_d     = pend_q;
    is_wr_d    = is_wr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      RX: begin
        if (rcv) begin
          frame_d = {frame_q[31:0], rx_data};
          tmo_d   = FRAME_TIMEOUT;
          if (byte_cnt_q == 3'd4) begin
            byte_cnt_d = 3'd0;
            state_d    = EXEC;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (byte_cnt_q != 3'd0 && tmo_q != 24'd0) begin
          tmo_d = tmo_q - 24'd1;
          if (tmo_q == 24'd1) byte_cnt_d = 3'd0;
        end
      end
      EXEC: begin
        byte_cnt_d = 3'd4;
        state_d    = TX_SEND;
        is_wr_d    = 1'b0;
        case (frame_q[39:32])
          8'h01: begin addr_d = frame_q[31:0]; reply_d = frame_q[31:0]; end
          8'h02: begin wr_d_d = frame_q[31:0]; reply_d = frame_q[31:0]; end
          8'h03: begin is_wr_d = 1'b1; state_d = ISSUE; reply_d = 32'h0000_0003; end
          8'h04: reply_d = ram_data_q;
          8'h05: begin state_d = ISSUE; reply_d = 32'h0000_0005; end
          8'h06: begin reply_d = count_q; count_d = count_q + 32'd1; end
          8'h07: reply_d = CONST_VAL;
          8'h08: begin reply_d = {29'b0, drop_q, pend_q, busy}; drop_d = 1'b0; end
          default: reply_d = 32'hFFFF_FFFF;
        endcase
      end
      ISSUE: if (!busy) state_d = TX_SEND;
      TX_SEND: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = reply_q[31:24];
          state_d    = TX_ACK;
        end
      end
      TX_ACK: begin
        if (!tx_ready) begin
          reply_d    = {reply_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q - 3'd1;
          state_d    = (byte_cnt_q == 3'd1) ? TX_DONE : TX_SEND;
        end
      end
      TX_DONE: begin
        if (tx_ready) begin
          state_d    = RX;
          byte_cnt_d = 3'd0;
        end
      end
      default: state_d = RX;
    endcase

    // A byte arriving while a command is in flight is lost; STATUS reports it.
    if (rcv && state_q != RX) drop_d = 1'b1;
    if (rd_rdy) begin
      ram_data_d = rd_d;
      pend_d     = 1'b0;
    end
    if (rd_req) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX;
      byte_cnt_q <= 3'd0;
      tmo_q      <= 24'd0;
      frame_q    <= 40'd0;
      reply_q    <= 32'd0;
      addr_q     <= 32'd0;
      wr_d_q     <= 32'd0;
      ram_data_q <= 32'd0;
      count_q    <= 32'd0;
      drop_q     <= 1'b0;
      pend_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      frame_q    <= frame_d;
      reply_q    <= reply_d;
      addr_q     <= addr_d;
      wr_d_q     <= wr_d_d;
      ram_data_q <= ram_data_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
      is_wr_q    <= is_wr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_hram_cmd_parser.sv
// Directed bench for hram_cmd_parser: a table of command frames with hand-computed
// replies, plus sequences for busy hold-off, frame timeout, dropped bytes and reset.
module tb_hram_cmd_parser;

  localparam int FT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rcv;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [31:0] addr;
  logic [31:0] wr_d;
  logic        wr_req;
  logic        rd_req;
  logic        busy;
  logic        rd_rdy;
  logic [31:0] rd_d;

  hram_cmd_parser #(.FRAME_TIMEOUT(24'd20), .CONST_VAL(32'd259)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rcv(rcv),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .addr(addr), .wr_d(wr_d), .wr_req(wr_req), .rd_req(rd_req),
    .busy(busy), .rd_rdy(rd_rdy), .rd_d(rd_d)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int viol = 0;
  logic [7:0] txq[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] opnd;
    logic [31:0] exp;
    int          exp_wr;
    int          exp_rd;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Request monitor, sampled mid-cycle after inputs have settled.
  initial forever begin
    @(negedge clk); #2;
    if (wr_req) wr_cnt++;
    if (rd_req) rd_cnt++;
    if ((wr_req && rd_req) || ((wr_req || rd_req) && busy)) viol++;
  end

  // Transmitter: accepts a byte a couple of cycles after tx_start, busy for 3 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        txq.push_back(tx_data);
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Memory controller: returns read data 3 cycles after rd_req.
  initial begin
    rd_rdy = 1'b0;
    rd_d   = 32'h0;
    forever begin
      @(negedge clk); #2;
      if (rd_req) begin
        repeat (3) @(negedge clk);
        rd_d   = 32'hCAFE_F00D;
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rcv     = 1'b1;
    @(negedge clk);
    rcv     = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] opnd);
    txq.delete();
    send_byte(cmd);
    send_byte(opnd[31:24]);
    send_byte(opnd[23:16]);
    send_byte(opnd[15:8]);
    send_byte(opnd[7:0]);
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 400 && txq.size() < n; i++) @(negedge clk);
  endtask

  task automatic get_reply(input string name, input logic [31:0] exp);
    logic [31:0] r;
    wait_q(4);
    chk({name, " byte count"}, txq.size(), 4);
    if (txq.size() >= 4) begin
      r = {txq[0], txq[1], txq[2], txq[3]};
      chk({name, " reply"}, r, exp);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int w0, r0;
    reset = 1'b1; rx_data = 8'h00; rcv = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_start", tx_start, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset addr", addr, 0);
    chk("reset wr_d", wr_d, 0);
    chk("reset wr_req", wr_req, 0);
    chk("reset rd_req", rd_req, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{8'h01, 32'h0000_1234, 32'h0000_1234, 0, 0};
    vecs[1] = '{8'h02, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0};
    vecs[2] = '{8'h05, 32'h0000_0000, 32'h0000_0005, 0, 1};
    vecs[3] = '{8'h04, 32'h0000_0000, 32'hCAFE_F00D, 0, 0};
    vecs[4] = '{8'h06, 32'h0000_0000, 32'h0000_0000, 0, 0};
    vecs[5] = '{8'h06, 32'h1111_1111, 32'h0000_0001, 0, 0};
    vecs[6] = '{8'h06, 32'h0000_0000, 32'h0000_0002, 0, 0};
    vecs[7] = '{8'h07, 32'h0000_0000, 32'h0000_0103, 0, 0};
    vecs[8] = '{8'h55, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0};
    vecs[9] = '{8'h08, 32'h0000_0000, 32'h0000_0000, 0, 0};

    for (int i = 0; i < 10; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      send_frame(vecs[i].cmd, vecs[i].opnd);
      get_reply($sformatf("vec%0d cmd %h", i, vecs[i].cmd), vecs[i].exp);
      chk($sformatf("vec%0d wr_req pulses", i), wr_cnt - w0, vecs[i].exp_wr);
      chk($sformatf("vec%0d rd_req pulses", i), rd_cnt - r0, vecs[i].exp_rd);
    end
    chk("addr after ADDR", addr, 32'h0000_1234);
    chk("wr_d after LOAD", wr_d, 32'hDEAD_BEEF);

    // WRITE held off by busy for 10 cycles
    busy = 1'b1;
    w0 = wr_cnt;
    send_frame(8'h03, 32'h0);
    repeat (10) @(negedge clk);
    chk("wr_req while busy", wr_cnt - w0, 0);
    busy = 1'b0;
    #1;
    chk("wr_req first idle cycle", wr_req, 1);
    chk("wr_d at write", wr_d, 32'hDEAD_BEEF);
    get_reply("write", 32'h0000_0003);
    chk("write single pulse", wr_cnt - w0, 1);

    // partial frame discarded after exactly FT idle cycles
    txq.delete();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (FT - 1) @(negedge clk);
    send_frame(8'h07, 32'h0);
    get_reply("const after timeout", 32'h0000_0103);

    // byte arriving during transmit sets the sticky drop flag
    send_frame(8'h06, 32'h0);
    wait_q(1);
    send_byte(8'hAA);
    get_reply("count 4th", 32'h0000_0003);
    send_frame(8'h08, 32'h0);
    get_reply("status drop set", 32'h0000_0004);
    send_frame(8'h08, 32'h0);
    get_reply("status drop clear", 32'h0000_0000);

    // reset while ISSUE waits on busy: no request, no reply
    busy = 1'b1;
    w0 = wr_cnt;
    send_frame(8'h03, 32'h0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    busy = 1'b0;
    repeat (30) @(negedge clk);
    chk("no wr_req after reset", wr_cnt - w0, 0);
    chk("no tx after reset", txq.size(), 0);
    chk("addr cleared by reset", addr, 0);

    // reset mid-transmit: no further tx_start
    send_frame(8'h07, 32'h0);
    wait_q(1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("tx stops after reset", txq.size(), 1);

    send_frame(8'h06, 32'h0);
    get_reply("count after reset", 32'h0000_0000);
    chk("req protocol violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hram_cmd_parser.md
HRAM_CMD_PARSER -- requirements
Module: hram_cmd_parser

Interface
REQ-001 SHALL have parameter FRAME_TIMEOUT, default 24'd1_000_000: idle clk cycles after which a partial command frame is discarded.
REQ-002 SHALL have parameter CONST_VAL, default 32'd259: value returned by CONST command.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rcv  input  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  output  8  byte to transmit.
REQ-008 tx_start  output  1  one-cycle transmit strobe.
REQ-009 tx_ready  input  1  high = transmitter idle.
REQ-010 addr  output  32  HyperRAM address to controller.
REQ-011 wr_d  output  32  HyperRAM write data to controller.
REQ-012 wr_req  output  1  one-cycle write request.
REQ-013 rd_req  output  1  one-cycle read request.
REQ-014 busy  input  1  controller busy.
REQ-015 rd_rdy  input  1  read data valid strobe.
REQ-016 rd_d  input  32  read data from controller.

Function
REQ-017 Frame = 5 bytes: command byte, then 32-bit operand MSB first; SHALL assemble the frame from rcv strobes.
REQ-018 States SHALL be RX, EXEC, ISSUE, TX_SEND, TX_ACK, TX_DONE; reset state RX.
REQ-019 RX: on the 5th rcv go to EXEC next cycle; bytes received outside RX SHALL be dropped and set sticky drop flag.
REQ-020 RX: if 1..4 bytes held and FRAME_TIMEOUT cycles pass with no rcv, byte count SHALL clear to 0; timeout counter restarts on every rcv.
REQ-021 EXEC, one cycle, by command: 0x01 ADDR addr<=operand, reply operand; 0x02 LOAD wr_d<=operand, reply operand; 0x03 WRITE -> ISSUE, reply 0x00000003; 0x04 READ reply ram_data; 0x05 READ_REQ -> ISSUE, reply 0x00000005; 0x06 COUNT reply count then count+1; 0x07 CONST reply CONST_VAL; 0x08 STATUS reply {29'b0, drop flag, pending read, busy}, then drop flag clears; other codes reply 0xFFFFFFFF.
REQ-022 Non-issue commands go EXEC -> TX_SEND.
REQ-023 ISSUE: wait while busy=1; first cycle with busy=0 SHALL pulse wr_req or rd_req exactly one cycle, then TX_SEND.
REQ-024 wr_req and rd_req SHALL never be high together and never be high while busy=1 in the same cycle.
REQ-025 ram_data SHALL capture rd_d on every rd_rdy cycle, in any state; pending read set on rd_req, cleared on rd_rdy.
REQ-026 count SHALL be 32-bit, wrap 0xFFFFFFFF -> 0.
REQ-027 TX_SEND: when tx_ready=1 pulse tx_start one cycle with tx_data = reply[31:24], go TX_ACK.
REQ-028 TX_ACK: wait for tx_ready=0 (transmitter acceptance, may take 2+ cycles), shift reply left 8, decrement byte count; 4 bytes sent -> TX_DONE, else TX_SEND.
REQ-029 TX_DONE: wait tx_ready=1, then RX with byte count 0.
REQ-030 Exactly 4 reply bytes per frame, MSB first; tx_start held low outside TX_SEND pulse.

Reset
REQ-031 On reset: state RX, frame byte count 0, timeout counter 0, addr 0, wr_d 0, ram_data 0, count 0, drop flag 0, pending read 0.
REQ-032 On reset: wr_req, rd_req, tx_start = 0, tx_data = 0x00.
REQ-033 Reset mid-frame, mid-ISSUE or mid-transmit SHALL abandon operation without issuing a request or further tx_start.

Verification
REQ-034 Send 01 00 00 12 34 -> addr=0x00001234; tx bytes 00 00 12 34.
REQ-035 LOAD 0xDEADBEEF, then WRITE with busy=1 for 10 cycles -> wr_req single pulse on first busy=0 cycle, wr_d=0xDEADBEEF; reply 00 00 00 03.
REQ-036 READ_REQ, model returns rd_d=0xCAFEF00D with rd_rdy; then READ -> reply CA FE F0 0D.
REQ-037 Send 2 bytes, idle FRAME_TIMEOUT cycles, send 07 00 00 00 00 -> reply 00 00 01 03.
REQ-038 COUNT three times -> replies 0, 1, 2; byte sent during transmit -> next STATUS bit2=1, following STATUS bit2=0.
REQ-039 Unknown command 0x55 -> reply FF FF FF FF; no wr_req/rd_req pulse.
